// File: rtl/entity_vector_sequencer_pkg.sv
// Shared types and ROM word field positions for the entity vector sequencer.
package entity_vector_sequencer_pkg;

  localparam int unsigned PKG_ADDR_WIDTH = 16;
  localparam int unsigned PKG_OUT_WIDTH  = 8;
  localparam int unsigned PKG_MAX_POINTS = 64;

  localparam int unsigned PT_DY_LSB   = 0;
  localparam int unsigned PT_DY_MSB   = PKG_OUT_WIDTH - 1;
  localparam int unsigned PT_DX_LSB   = PKG_OUT_WIDTH;
  localparam int unsigned PT_DX_MSB   = 2 * PKG_OUT_WIDTH - 1;
  localparam int unsigned PT_DRAW_BIT = 2 * PKG_OUT_WIDTH;
  localparam int unsigned PT_LAST_BIT = 2 * PKG_OUT_WIDTH + 1;

  typedef struct packed {
    logic                     last;
    logic                     draw;
    logic [PKG_OUT_WIDTH-1:0] dx;
    logic [PKG_OUT_WIDTH-1:0] dy;
  } point_word_t;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StFetch,
    StCapture,
    StEmit,
    StDone
  } seq_state_t;

endpackage

// File: rtl/entity_vector_sequencer_if.sv
// Enemy inputs, image ROM port and beam-point outputs of the sequencer.
interface entity_vector_sequencer_if
  import entity_vector_sequencer_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH = PKG_ADDR_WIDTH,
  parameter int unsigned OUT_WIDTH    = PKG_OUT_WIDTH
);
  logic                     frame_start;
  logic                     point_tick;
  logic [OUT_WIDTH-1:0]     xenemy1, xenemy2, xenemy3;
  logic [OUT_WIDTH-1:0]     yenemy1, yenemy2, yenemy3;
  logic                     spawn_enemy1, spawn_enemy2, spawn_enemy3;
  logic [ADDRESSWIDTH-1:0]  adr_enemy1, adr_enemy2, adr_enemy3;
  logic [ADDRESSWIDTH-1:0]  rom_adr;
  logic [2*OUT_WIDTH+1:0]   rom_data;
  logic [OUT_WIDTH-1:0]     xout, yout;
  logic                     draw, out_valid, busy, frame_done;

  modport master (
    output frame_start, point_tick,
    output xenemy1, xenemy2, xenemy3, yenemy1, yenemy2, yenemy3,
    output spawn_enemy1, spawn_enemy2, spawn_enemy3, adr_enemy1, adr_enemy2, adr_enemy3,
    output rom_data,
    input  rom_adr, xout, yout, draw, out_valid, busy, frame_done
  );

  modport slave (
    input  frame_start, point_tick,
    input  xenemy1, xenemy2, xenemy3, yenemy1, yenemy2, yenemy3,
    input  spawn_enemy1, spawn_enemy2, spawn_enemy3, adr_enemy1, adr_enemy2, adr_enemy3,
    input  rom_data,
    output rom_adr, xout, yout, draw, out_valid, busy, frame_done
  );
endinterface

// File: rtl/entity_vector_sequencer_vec_offset_sat.sv
// Unsigned position + offset with saturation to all-ones; clip flags the overflow.
module entity_vector_sequencer_vec_offset_sat #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] pos,
  input  logic [WIDTH-1:0] off,
  output logic [WIDTH-1:0] sum,
  output logic             clip
);
  logic [WIDTH:0] wide;

  always_comb begin
    wide = {1'b0, pos} + {1'b0, off};
    clip = wide[WIDTH];
    sum  = clip ? '1 : wide[WIDTH-1:0];
  end
endmodule

// File: rtl/entity_vector_sequencer.sv
// Per-frame walker: snapshots three enemies, reads each spawned image from ROM and
// emits one offset beam point per point_tick.
module entity_vector_sequencer
  import entity_vector_sequencer_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH = PKG_ADDR_WIDTH,
  parameter int unsigned OUT_WIDTH    = PKG_OUT_WIDTH,
  parameter int unsigned MAX_POINTS   = PKG_MAX_POINTS
) (
  input logic                     clk,
  input logic                     rst,
  entity_vector_sequencer_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MAX_POINTS) + 1;

  seq_state_t              state;
  logic [OUT_WIDTH-1:0]    x_q [3];
  logic [OUT_WIDTH-1:0]    y_q [3];
  logic [ADDRESSWIDTH-1:0] adr_q [3];
  logic [2:0]              spawn_q;
  logic [1:0]              ent_q;
  logic [CNT_W-1:0]        pt_cnt_q;
  logic [ADDRESSWIDTH-1:0] rom_adr_q;
  logic [OUT_WIDTH-1:0]    pend_x, pend_y, xout_q, yout_q;
  logic                    pend_draw, pend_last;
  logic                    draw_q, out_valid_q, busy_q, frame_done_q;

  logic [OUT_WIDTH-1:0]    cur_x, cur_y, sum_x, sum_y;
  logic [ADDRESSWIDTH-1:0] cur_adr;
  logic                    cur_spawn, clip_x, clip_y;

  always_comb begin
    cur_x     = x_q[0];
    cur_y     = y_q[0];
    cur_adr   = adr_q[0];
    cur_spawn = spawn_q[0];
    case (ent_q)
      2'd1: begin
        cur_x = x_q[1]; cur_y = y_q[1]; cur_adr = adr_q[1]; cur_spawn = spawn_q[1];
      end
      2'd2: begin
        cur_x = x_q[2]; cur_y = y_q[2]; cur_adr = adr_q[2]; cur_spawn = spawn_q[2];
      end
      default: ;
    endcase
  end

  entity_vector_sequencer_vec_offset_sat #(.WIDTH(OUT_WIDTH)) u_sat_x (
    .pos  (cur_x),
    .off  (bus.rom_data[PT_DX_MSB:PT_DX_LSB]),
    .sum  (sum_x),
    .clip (clip_x)
  );

  entity_vector_sequencer_vec_offset_sat #(.WIDTH(OUT_WIDTH)) u_sat_y (
    .pos  (cur_y),
    .off  (bus.rom_data[PT_DY_MSB:PT_DY_LSB]),
    .sum  (sum_y),
    .clip (clip_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      for (int i = 0; i < 3; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        adr_q[i] <= '0;
      end
      spawn_q      <= '0;
      ent_q        <= '0;
      pt_cnt_q     <= '0;
      rom_adr_q    <= '0;
      pend_x       <= '0;
      pend_y       <= '0;
      pend_draw    <= 1'b0;
      pend_last    <= 1'b0;
      xout_q       <= '0;
      yout_q       <= '0;
      draw_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.frame_start) begin
            x_q     <= '{bus.xenemy1, bus.xenemy2, bus.xenemy3};
            y_q     <= '{bus.yenemy1, bus.yenemy2, bus.yenemy3};
            adr_q   <= '{bus.adr_enemy1, bus.adr_enemy2, bus.adr_enemy3};
            spawn_q <= {bus.spawn_enemy3, bus.spawn_enemy2, bus.spawn_enemy1};
            ent_q   <= '0;
            busy_q  <= 1'b1;
            state   <= StSelect;
          end
        end
        StSelect: begin
          // Beam stays off while travelling to the next image.
          draw_q <= 1'b0;
          if (ent_q == 2'd3) begin
            state <= StDone;
          end else if (!cur_spawn) begin
            ent_q <= ent_q + 2'd1;
          end else begin
            rom_adr_q <= cur_adr;
            pt_cnt_q  <= '0;
            state     <= StFetch;
          end
        end
        StFetch: state <= StCapture;
        StCapture: begin
          pend_x    <= sum_x;
          pend_y    <= sum_y;
          pend_draw <= bus.rom_data[PT_DRAW_BIT] & ~clip_x & ~clip_y;
          pend_last <= bus.rom_data[PT_LAST_BIT];
          state     <= StEmit;
        end
        StEmit: begin
          if (bus.point_tick) begin
            xout_q      <= pend_x;
            yout_q      <= pend_y;
            draw_q      <= pend_draw;
            out_valid_q <= 1'b1;
            pt_cnt_q    <= pt_cnt_q + CNT_W'(1);
            if (pend_last || pt_cnt_q == CNT_W'(MAX_POINTS - 1)) begin
              ent_q <= ent_q + 2'd1;
              state <= StSelect;
            end else begin
              rom_adr_q <= rom_adr_q + ADDRESSWIDTH'(1);
              state     <= StFetch;
            end
          end
        end
        StDone: begin
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
          draw_q       <= 1'b0;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.rom_adr    = rom_adr_q;
  assign bus.xout       = xout_q;
  assign bus.yout       = yout_q;
  assign bus.draw       = draw_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_entity_vector_sequencer.sv
// Bench for entity_vector_sequencer: vector table, directed corner sequences and random frames
// compared against a list-of-points model built from the image ROM contents.
module tb_entity_vector_sequencer;
  import entity_vector_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  entity_vector_sequencer_if bus ();

  entity_vector_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [17:0] rom [0:65535];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_adr];

  logic [7:0]  ex [3];
  logic [7:0]  ey [3];
  logic        esp [3];
  logic [15:0] ead [3];
  assign bus.xenemy1 = ex[0];
  assign bus.xenemy2 = ex[1];
  assign bus.xenemy3 = ex[2];
  assign bus.yenemy1 = ey[0];
  assign bus.yenemy2 = ey[1];
  assign bus.yenemy3 = ey[2];
  assign bus.spawn_enemy1 = esp[0];
  assign bus.spawn_enemy2 = esp[1];
  assign bus.spawn_enemy3 = esp[2];
  assign bus.adr_enemy1 = ead[0];
  assign bus.adr_enemy2 = ead[1];
  assign bus.adr_enemy3 = ead[2];

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       d;
  } pt_t;

  typedef struct {
    logic [7:0] x, y, dx, dy;
    logic       d;
    logic [7:0] ex_x, ex_y;
    logic       ex_d;
  } vec_t;

  pt_t obs_q[$];
  pt_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  start_cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.out_valid) obs_q.push_back('{x: bus.xout, y: bus.yout, d: bus.draw});
      if (bus.frame_done) begin
        if (done_cnt == 0) done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: walk each spawned image word by word, saturating each axis independently.
  task automatic build_expected();
    int a, sx, sy;
    bit cx, cy;
    point_word_t pw;
    exp_q.delete();
    for (int e = 0; e < 3; e++) begin
      if (esp[e]) begin
        a = int'(ead[e]);
        for (int k = 0; k < 64; k++) begin
          pw = point_word_t'(rom[a]);
          sx = int'(ex[e]) + int'(pw.dx);
          sy = int'(ey[e]) + int'(pw.dy);
          cx = (sx > 255);
          cy = (sy > 255);
          exp_q.push_back('{x: cx ? 8'hFF : 8'(sx), y: cy ? 8'hFF : 8'(sy),
                            d: pw.draw && !cx && !cy});
          if (pw.last) break;
          a = (a + 1) % 65536;
        end
      end
    end
  endtask

  task automatic run_frame(input int tick_pct, input int mid, input logic [7:0] new_x);
    obs_q.delete();
    done_cnt = 0;
    bus.frame_start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    bus.frame_start = 1'b0;
    for (int j = 0; j < 3000 && done_cnt == 0; j++) begin
      bus.point_tick = ($urandom_range(99) < tick_pct);
      if (j == mid) begin
        bus.frame_start = 1'b1;
        ex[0] = new_x;
      end else begin
        bus.frame_start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.point_tick = 1'b0;
    bus.frame_start = 1'b0;
    if (done_cnt == 0) check("frame timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compare_frame(input string name);
    int n;
    check({name, " points"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s x[%0d]", name, i), obs_q[i].x, exp_q[i].x);
      check($sformatf("%s y[%0d]", name, i), obs_q[i].y, exp_q[i].y);
      check($sformatf("%s d[%0d]", name, i), obs_q[i].d, exp_q[i].d);
    end
    check({name, " frame_done"}, done_cnt, 1);
  endtask

  task automatic load_img1();
    rom[16'h0200] = {1'b0, 1'b0, 8'd0, 8'd0};
    rom[16'h0200 + 1] = {1'b0, 1'b1, 8'd5, 8'd5};
    rom[16'h0200 + 2] = {1'b1, 1'b1, 8'd5, 8'd0};
    esp = '{1'b1, 1'b0, 1'b0};
    ex[0] = 8'd10;
    ey[0] = 8'd20;
    ead[0] = 16'h0200;
  endtask

  vec_t tv [7];

  initial begin
    rst = 1'b1;
    bus.frame_start = 1'b0;
    bus.point_tick = 1'b0;
    for (int i = 0; i < 65536; i++) rom[i] = '0;
    for (int e = 0; e < 3; e++) begin
      ex[e] = '0; ey[e] = '0; esp[e] = 1'b0; ead[e] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset xout", bus.xout, 0);
    check("reset yout", bus.yout, 0);
    check("reset draw", bus.draw, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset frame_done", bus.frame_done, 0);
    check("reset rom_adr", bus.rom_adr, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-point images: plain sums, exact 255, and per-axis carry clipping.
    tv[0] = '{x: 10,  y: 20,  dx: 0,   dy: 0,   d: 1, ex_x: 10,  ex_y: 20,  ex_d: 1};
    tv[1] = '{x: 250, y: 3,   dx: 10,  dy: 4,   d: 1, ex_x: 255, ex_y: 7,   ex_d: 0};
    tv[2] = '{x: 0,   y: 0,   dx: 255, dy: 255, d: 1, ex_x: 255, ex_y: 255, ex_d: 1};
    tv[3] = '{x: 1,   y: 1,   dx: 255, dy: 0,   d: 1, ex_x: 255, ex_y: 1,   ex_d: 0};
    tv[4] = '{x: 128, y: 128, dx: 127, dy: 127, d: 0, ex_x: 255, ex_y: 255, ex_d: 0};
    tv[5] = '{x: 100, y: 200, dx: 55,  dy: 56,  d: 1, ex_x: 155, ex_y: 255, ex_d: 0};
    tv[6] = '{x: 7,   y: 9,   dx: 3,   dy: 4,   d: 1, ex_x: 10,  ex_y: 13,  ex_d: 1};
    for (int i = 0; i < 7; i++) begin
      esp = '{1'b1, 1'b0, 1'b0};
      ex[0] = tv[i].x;
      ey[0] = tv[i].y;
      ead[0] = 16'h0100;
      rom[16'h0100] = {1'b1, tv[i].d, tv[i].dx, tv[i].dy};
      run_frame(50, -1, 8'd0);
      check($sformatf("vec%0d count", i), obs_q.size(), 1);
      if (obs_q.size() > 0) begin
        check($sformatf("vec%0d x", i), obs_q[0].x, tv[i].ex_x);
        check($sformatf("vec%0d y", i), obs_q[0].y, tv[i].ex_y);
        check($sformatf("vec%0d d", i), obs_q[0].d, tv[i].ex_d);
      end
    end

    // Three-point image on enemy 1.
    load_img1();
    run_frame(40, -1, 8'd0);
    exp_q.delete();
    exp_q.push_back('{x: 10, y: 20, d: 0});
    exp_q.push_back('{x: 15, y: 25, d: 1});
    exp_q.push_back('{x: 15, y: 20, d: 1});
    compare_frame("img1");

    // Nothing spawned: frame_done exactly 5 cycles after frame_start.
    esp = '{1'b0, 1'b0, 1'b0};
    run_frame(100, -1, 8'd0);
    check("empty points", obs_q.size(), 0);
    check("empty done latency", done_cyc - start_cyc, 5);
    check("empty busy low", bus.busy, 0);

    // Missing LAST bit caps at 64 points, then enemy 2, then a wrapping image on enemy 3.
    for (int i = 0; i < 70; i++) rom[16'h1000 + i] = {1'b0, 1'b1, 8'(i), 8'(2 * i)};
    rom[16'h2000] = {1'b1, 1'b1, 8'd1, 8'd1};
    for (int i = 0; i < 4; i++) rom[(16'hFFFE + i) % 65536] = {i == 3, 1'b1, 8'(i), 8'd0};
    esp = '{1'b1, 1'b1, 1'b1};
    ex = '{8'd0, 8'd3, 8'd60};
    ey = '{8'd1, 8'd4, 8'd70};
    ead = '{16'h1000, 16'h2000, 16'hFFFE};
    build_expected();
    run_frame(100, -1, 8'd0);
    check("cap total points", obs_q.size(), 69);
    compare_frame("cap");

    // frame_start and enemy change mid-frame: no restart, old snapshot used.
    load_img1();
    build_expected();
    run_frame(50, 6, 8'd100);
    compare_frame("midframe old");
    check("midframe no restart", bus.busy, 0);
    build_expected();
    run_frame(50, -1, 8'd0);
    check("midframe new x0", (obs_q.size() > 0) ? int'(obs_q[0].x) : -1, 100);
    compare_frame("midframe new");

    // Async reset while waiting in EMIT.
    load_img1();
    obs_q.delete();
    bus.frame_start = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    bus.point_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.point_tick = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre-reset busy", bus.busy, 1);
    check("pre-reset xout", bus.xout, 10);
    check("pre-reset yout", bus.yout, 20);
    #2 rst = 1'b1;
    #1;
    check("async rst xout", bus.xout, 0);
    check("async rst yout", bus.yout, 0);
    check("async rst draw", bus.draw, 0);
    check("async rst busy", bus.busy, 0);
    check("async rst out_valid", bus.out_valid, 0);
    check("async rst rom_adr", bus.rom_adr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    build_expected();
    run_frame(60, -1, 8'd0);
    compare_frame("after reset");

    // Random frames.
    for (int it = 0; it < 20; it++) begin
      for (int e = 0; e < 3; e++) begin
        int len;
        logic [15:0] base;
        esp[e] = 1'($urandom_range(1));
        ex[e] = 8'($urandom_range(255));
        ey[e] = 8'($urandom_range(255));
        base = 16'h4000 + 16'(it * 64 + e * 16);
        ead[e] = base;
        len = $urandom_range(10, 1);
        for (int k = 0; k < len; k++)
          rom[base + 16'(k)] = {k == len - 1, 1'($urandom_range(1)),
                                8'($urandom_range(255)), 8'($urandom_range(255))};
      end
      build_expected();
      run_frame($urandom_range(100, 20), -1, 8'd0);
      compare_frame($sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
